// File: rtl/div_pipe_sched_pkg.sv
// Shared divider definitions: default widths, divider latency and id width helper.
package div_pipe_sched_pkg;

    localparam int unsigned A_WIDTH_DEF = 40;
    localparam int unsigned B_WIDTH_DEF = 32;
    localparam int unsigned DIV_LAT_DEF = 63;

    // Width of a requester id; never narrower than one bit.
    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/div_pipe_sched_rr_arb.sv
// Round-robin arbiter: one-hot grant, search starts after the last granted requester.
module rr_arb
    import div_pipe_sched_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);

    localparam int unsigned PW = id_width(N);

    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_next;
    logic          found;

    // Pick the first requester at or after ptr, wrapping; remember the slot after it.
    always_comb begin
        grant    = '0;
        ptr_next = ptr;
        found    = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            for (int unsigned i = 0; i < N; i++) begin
                if (!found && req[i] && ((32'(ptr) + k == i) || (32'(ptr) + k == i + N))) begin
                    grant[i] = 1'b1;
                    found    = 1'b1;
                    ptr_next = (i == N - 1) ? '0 : PW'(i + 1);
                end
            end
        end
    end

    // Pointer moves only when the grant is actually taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= ptr_next;
        end
    end

endmodule

// File: rtl/div_pipe_sched.sv
// Multi-requester scheduler in front of an external fixed-latency pipelined divider.
module div_pipe_sched
    import div_pipe_sched_pkg::*;
#(
    parameter int unsigned A_WIDTH = A_WIDTH_DEF,
    parameter int unsigned B_WIDTH = B_WIDTH_DEF,
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned DIV_LAT = DIV_LAT_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          issue_en,
    input  logic [N_REQ-1:0]              req_valid,
    output logic [N_REQ-1:0]              req_ready,
    input  logic [N_REQ*A_WIDTH-1:0]      req_a,
    input  logic [N_REQ*B_WIDTH-1:0]      req_b,
    output logic [A_WIDTH-1:0]            div_a,
    output logic [B_WIDTH-1:0]            div_b,
    input  logic [A_WIDTH-1:0]            div_quotient,
    input  logic [B_WIDTH-1:0]            div_remainder,
    input  logic                          div_by_0,
    output logic                          rsp_valid,
    output logic [id_width(N_REQ)-1:0]    rsp_id,
    output logic [A_WIDTH-1:0]            rsp_quotient,
    output logic [B_WIDTH-1:0]            rsp_remainder,
    output logic                          rsp_div0,
    output logic [$clog2(DIV_LAT+2):0]    inflight,
    output logic                          busy
);

    localparam int unsigned IDW   = id_width(N_REQ);
    localparam int unsigned IFW   = $clog2(DIV_LAT + 2) + 1;
    // Operand register plus DIV_LAT+1 divider stages: the tag leaves the last
    // slot while the matching result sits on div_quotient/div_remainder.
    localparam int unsigned DEPTH = DIV_LAT + 2;

    logic [N_REQ-1:0]   arb_req;
    logic [N_REQ-1:0]   grant;
    logic               xfer;
    logic [IDW-1:0]     grant_id;
    logic [A_WIDTH-1:0] sel_a;
    logic [B_WIDTH-1:0] sel_b;
    logic [DEPTH-1:0]   tag_vld;
    logic [IDW-1:0]     tag_id [DEPTH];
    logic               tag_exit;

    assign arb_req = (issue_en && !rst) ? req_valid : '0;

    rr_arb #(.N(N_REQ)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (arb_req),
        .advance (xfer),
        .grant   (grant)
    );

    assign req_ready = grant;
    assign xfer      = |(req_valid & grant);
    assign tag_exit  = tag_vld[DEPTH-1];
    assign busy      = |inflight;

    // Select the granted requester's operands and id.
    always_comb begin
        grant_id = '0;
        sel_a    = '0;
        sel_b    = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                grant_id = IDW'(i);
                sel_a    = req_a[i*A_WIDTH +: A_WIDTH];
                sel_b    = req_b[i*B_WIDTH +: B_WIDTH];
            end
        end
    end

    // Operand register feeding the divider; holds when nothing is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_a <= '0;
            div_b <= '0;
        end else if (xfer) begin
            div_a <= sel_a;
            div_b <= sel_b;
        end
    end

    // Tag valid bits shift every cycle in lockstep with the divider.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_vld <= '0;
        end else begin
            tag_vld <= {tag_vld[DEPTH-2:0], xfer};
        end
    end

    // Tag ids ride alongside the valid bits; only meaningful where valid.
    always_ff @(posedge clk) begin
        tag_id[0] <= grant_id;
        for (int unsigned k = 1; k < DEPTH; k++) begin
            tag_id[k] <= tag_id[k-1];
        end
    end

    // Capture the divider result when its tag exits; hold otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid     <= 1'b0;
            rsp_id        <= '0;
            rsp_quotient  <= '0;
            rsp_remainder <= '0;
            rsp_div0      <= 1'b0;
        end else begin
            rsp_valid <= tag_exit;
            if (tag_exit) begin
                rsp_id        <= tag_id[DEPTH-1];
                rsp_quotient  <= div_quotient;
                rsp_remainder <= div_remainder;
                rsp_div0      <= div_by_0;
            end
        end
    end

    // Outstanding count; an op retires on the edge that raises its rsp_valid,
    // which bounds the count at DEPTH under full throughput.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight <= '0;
        end else begin
            case ({xfer, tag_exit})
                2'b10:   inflight <= inflight + IFW'(1);
                2'b01:   inflight <= inflight - IFW'(1);
                default: inflight <= inflight;
            endcase
        end
    end

endmodule

// File: tb/tb_div_pipe_sched.sv
// Scoreboard bench for div_pipe_sched with a behavioural external divider.
module tb_div_pipe_sched;

    localparam int AW  = 40;
    localparam int BW  = 32;
    localparam int NR  = 4;
    localparam int DL  = 63;
    localparam int LAT = DL + 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              issue_en;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*AW-1:0]  req_a;
    logic [NR*BW-1:0]  req_b;
    logic [AW-1:0]     div_a;
    logic [BW-1:0]     div_b;
    logic [AW-1:0]     div_quotient;
    logic [BW-1:0]     div_remainder;
    logic              div_by_0;
    logic              rsp_valid;
    logic [1:0]        rsp_id;
    logic [AW-1:0]     rsp_quotient;
    logic [BW-1:0]     rsp_remainder;
    logic              rsp_div0;
    logic [7:0]        inflight;
    logic              busy;

    div_pipe_sched #(.A_WIDTH(AW), .B_WIDTH(BW), .N_REQ(NR), .DIV_LAT(DL)) dut (
        .clk           (clk),
        .rst           (rst),
        .issue_en      (issue_en),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_a         (req_a),
        .req_b         (req_b),
        .div_a         (div_a),
        .div_b         (div_b),
        .div_quotient  (div_quotient),
        .div_remainder (div_remainder),
        .div_by_0      (div_by_0),
        .rsp_valid     (rsp_valid),
        .rsp_id        (rsp_id),
        .rsp_quotient  (rsp_quotient),
        .rsp_remainder (rsp_remainder),
        .rsp_div0      (rsp_div0),
        .inflight      (inflight),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // External divider: DL+1 register stages after the operand register, never reset.
    logic [72:0] dpipe [DL+1];

    function automatic logic [72:0] divide(input logic [AW-1:0] a, input logic [BW-1:0] b);
        logic [AW-1:0] bx;
        logic [AW-1:0] rem;
        if (b == '0) return {1'b1, {AW{1'b1}}, a[BW-1:0]};
        bx  = {8'd0, b};
        rem = a % bx;
        return {1'b0, a / bx, rem[BW-1:0]};
    endfunction

    always @(posedge clk) begin
        dpipe[0] <= divide(div_a, div_b);
        for (int k = 1; k <= DL; k++) dpipe[k] <= dpipe[k-1];
    end

    assign div_by_0      = dpipe[DL][72];
    assign div_quotient  = dpipe[DL][71:32];
    assign div_remainder = dpipe[DL][31:0];

    // Hand-computed operands and results per requester.
    logic [AW-1:0] op_a  [NR];
    logic [BW-1:0] op_b  [NR];
    logic [AW-1:0] exp_q [NR];
    logic [BW-1:0] exp_r [NR];
    logic          exp_z [NR];

    typedef struct {
        int            id;
        logic [AW-1:0] q;
        logic [BW-1:0] r;
        logic          dz;
        int            due;
    } exp_t;

    exp_t sb[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every response must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rsp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_rsp: got id %0d expected none (cycle %0d)", rsp_id, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_cycle", 64'(cyc), 64'(e.due));
                chk("rsp_id", 64'(rsp_id), 64'(e.id));
                chk("rsp_quotient", 64'(rsp_quotient), 64'(e.q));
                chk("rsp_remainder", 64'(rsp_remainder), 64'(e.r));
                chk("rsp_div0", 64'(rsp_div0), 64'(e.dz));
            end
        end
    end

    // One cycle: check the grant and, if a transfer is expected, record its response.
    task automatic step(input int exp_g);
        exp_t e;
        logic [NR-1:0] oh;
        @(negedge clk);
        oh = (exp_g < 0) ? '0 : NR'(1 << exp_g);
        chk("req_ready", 64'(req_ready), 64'(oh));
        if (exp_g >= 0) begin
            e.id  = exp_g;
            e.q   = exp_q[exp_g];
            e.r   = exp_r[exp_g];
            e.dz  = exp_z[exp_g];
            e.due = cyc + LAT + 1;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (busy === 1'b0) break;
        end
        chk("drain_busy", 64'(busy), 64'd0);
        chk("drain_inflight", 64'(inflight), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int cnt;
        op_a[0] = 40'd100;           op_b[0] = 32'd7;
        exp_q[0] = 40'd14;           exp_r[0] = 32'd2;  exp_z[0] = 1'b0;
        op_a[1] = 40'd1000;          op_b[1] = 32'd33;
        exp_q[1] = 40'd30;           exp_r[1] = 32'd10; exp_z[1] = 1'b0;
        op_a[2] = 40'd5;             op_b[2] = 32'd0;
        exp_q[2] = 40'hFF_FFFF_FFFF; exp_r[2] = 32'd5;  exp_z[2] = 1'b1;
        op_a[3] = 40'hFF_FFFF_FFFF;  op_b[3] = 32'd1;
        exp_q[3] = 40'hFF_FFFF_FFFF; exp_r[3] = 32'd0;  exp_z[3] = 1'b0;
        for (int i = 0; i < NR; i++) begin
            req_a[i*AW +: AW] = op_a[i];
            req_b[i*BW +: BW] = op_b[i];
        end

        // Reset state, with requests pending and issue enabled.
        rst = 1'b1; issue_en = 1'b1; req_valid = 4'b1111;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_inflight", 64'(inflight), 64'd0);
        chk("rst_div_a", 64'(div_a), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0; req_valid = '0;
        @(posedge clk); #1;

        // Single op on requester 0.
        req_valid = 4'b0001;
        step(0);
        req_valid = '0;
        @(negedge clk);
        chk("op_div_a", 64'(div_a), 64'd100);
        chk("op_div_b", 64'(div_b), 64'd7);
        chk("op_inflight", 64'(inflight), 64'd1);
        @(posedge clk); #1;
        drain();

        // Divide by zero on requester 2.
        req_valid = 4'b0100;
        step(2);
        req_valid = '0;
        drain();

        // All requesters continuously valid; pointer now at 3.
        req_valid = 4'b1111;
        for (int k = 0; k < 80; k++) step((3 + k) % 4);

        // Hold issue; in-flight ops keep completing.
        issue_en = 1'b0;
        @(negedge clk);
        chk("inflight_sat", 64'(inflight), 64'(LAT));
        @(posedge clk); #1;
        for (int k = 0; k < 10; k++) step(-1);
        req_valid = '0; issue_en = 1'b1;
        drain();
        chk("hold_rsp_id", 64'(rsp_id), 64'd2);
        chk("hold_rsp_div0", 64'(rsp_div0), 64'd1);
        chk("hold_rsp_q", 64'(rsp_quotient), 64'(exp_q[2]));

        // Back-to-back all-ones dividend on requester 3.
        req_valid = 4'b1000;
        for (int k = 0; k < 5; k++) step(3);
        req_valid = '0;
        drain();

        // Reset with ops in flight; pointer left at requester 2.
        req_valid = 4'b1111;
        for (int k = 0; k < 22; k++) step(k % 4);
        req_valid = '0;
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        chk("mid_rst_inflight", 64'(inflight), 64'd0);
        chk("mid_rst_rsp_q", 64'(rsp_quotient), 64'd0);
        chk("mid_rst_div_a", 64'(div_a), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        cnt = 0;
        for (int k = 0; k < LAT + 4; k++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) cnt++;
        end
        chk("post_rst_rsp_count", 64'(cnt), 64'd0);
        chk("post_rst_inflight", 64'(inflight), 64'd0);
        @(posedge clk); #1;
        req_valid = 4'b1111;
        step(0);
        req_valid = '0;
        drain();

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
